// File: rtl/pc_redirect_if.sv
// Fetch-PC redirect bus between the resolve stages and the next-PC sequencer.
// Master supplies the resolved instruction context; slave returns the PC load.
interface pc_redirect_if;
    logic [31:0] pc;
    logic        busy;
    logic        exc_req;
    logic [3:0]  exc_cause;
    logic        eret;
    logic        jr;
    logic [31:0] jr_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] next_pc;
    logic        pc_load;
    logic        flush;

    modport master (
        output pc, busy, exc_req, exc_cause, eret,
        output jr, jr_target, jmp, jmp_target, br_taken, br_target,
        input  next_pc, pc_load, flush
    );

    modport slave (
        input  pc, busy, exc_req, exc_cause, eret,
        input  jr, jr_target, jmp, jmp_target, br_taken, br_target,
        output next_pc, pc_load, flush
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer with EPC/cause/EXL exception state.
// Optional perf counters enabled by defining PC_CTRL_PERF_EN.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_BASE = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    pc_redirect_if.slave bus,
    output logic [31:0] epc,
    output logic [3:0]  cause,
    output logic        exl,
    output logic [31:0] stall_cnt,
    output logic [31:0] redir_cnt
);

    typedef enum logic [1:0] {RUN, STALL, EXC_FLUSH} state_t;

    state_t      state, state_nxt;
    logic        pend_v, pend_v_nxt;
    logic [3:0]  pend_cause, pend_cause_nxt;
    logic [31:0] epc_nxt;
    logic [3:0]  cause_nxt;
    logic        exl_nxt;
    logic        redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            epc        <= '0;
            cause      <= '0;
            exl        <= 1'b0;
            pend_v     <= 1'b0;
            pend_cause <= '0;
        end else begin
            state      <= state_nxt;
            epc        <= epc_nxt;
            cause      <= cause_nxt;
            exl        <= exl_nxt;
            pend_v     <= pend_v_nxt;
            pend_cause <= pend_cause_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        epc_nxt        = epc;
        cause_nxt      = cause;
        exl_nxt        = exl;
        pend_v_nxt     = pend_v;
        pend_cause_nxt = pend_cause;
        redirect       = 1'b0;
        bus.next_pc    = bus.pc + 32'd4;
        bus.pc_load    = 1'b1;
        bus.flush      = 1'b0;

        if (rst) begin
            bus.next_pc = RESET_PC;
            bus.flush   = 1'b1;
            state_nxt   = RUN;
        end else if (state == EXC_FLUSH) begin
            bus.next_pc = bus.pc;
            bus.pc_load = 1'b0;
            bus.flush   = 1'b1;
            state_nxt   = RUN;
        end else if (state == STALL && bus.busy) begin
            // Trap raised under a stall is parked; the oldest one is kept.
            bus.next_pc = bus.pc;
            bus.pc_load = 1'b0;
            if (bus.exc_req && !pend_v) begin
                pend_v_nxt     = 1'b1;
                pend_cause_nxt = bus.exc_cause;
            end
        end else begin
            state_nxt = RUN;
            priority case (1'b1)
                bus.exc_req || pend_v: begin
                    bus.next_pc    = EXC_BASE;
                    bus.flush      = 1'b1;
                    redirect       = 1'b1;
                    epc_nxt        = exl ? epc : bus.pc;
                    cause_nxt      = pend_v ? pend_cause : bus.exc_cause;
                    exl_nxt        = 1'b1;
                    pend_v_nxt     = 1'b0;
                    state_nxt      = EXC_FLUSH;
                end
                bus.eret && exl: begin
                    bus.next_pc = epc;
                    bus.flush   = 1'b1;
                    redirect    = 1'b1;
                    exl_nxt     = 1'b0;
                end
                bus.busy: begin
                    bus.next_pc = bus.pc;
                    bus.pc_load = 1'b0;
                    state_nxt   = STALL;
                end
                bus.jr: begin
                    bus.next_pc = bus.jr_target;
                    bus.flush   = 1'b1;
                    redirect    = 1'b1;
                end
                bus.jmp: begin
                    bus.next_pc = bus.jmp_target;
                    bus.flush   = 1'b1;
                    redirect    = 1'b1;
                end
                bus.br_taken: begin
                    bus.next_pc = bus.br_target;
                    bus.flush   = 1'b1;
                    redirect    = 1'b1;
                end
                default: begin
                    bus.next_pc = bus.pc + 32'd4;
                end
            endcase
        end
    end

`ifdef PC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (!bus.pc_load && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect && redir_cnt != 32'hFFFF_FFFF)
                redir_cnt <= redir_cnt + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = redirect;
    assign stall_cnt   = '0;
    assign redir_cnt   = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomized bench for pc_redirect_ctrl against a cycle-level rule model.
// Counter expectations follow PC_CTRL_PERF_EN.
`timescale 1ns/1ps
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_BASE = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] epc, stall_cnt, redir_cnt;
    logic [3:0]  cause;
    logic        exl;
    int          checks = 0;
    int          errors = 0;

    pc_redirect_if bus ();

    pc_redirect_ctrl #(.RESET_PC(RESET_PC), .EXC_BASE(EXC_BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .epc(epc), .cause(cause), .exl(exl),
        .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
    );

    always #5 clk = ~clk;

    // Model: what the controller must remember between cycles
    logic [31:0] m_epc, m_sc, m_rc, last_np;
    logic [3:0]  m_cause, m_pcause;
    logic        m_exl, m_pend, m_in_flush_slot, m_stalled;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.busy = 0; bus.exc_req = 0; bus.exc_cause = 0; bus.eret = 0;
        bus.jr = 0; bus.jmp = 0; bus.br_taken = 0;
        bus.jr_target = 32'h1000; bus.jmp_target = 32'h2000;
        bus.br_target = 32'h3000;
    endtask

    task automatic step();
        logic [31:0] e_np, n_epc, n_sc, n_rc;
        logic [3:0]  n_cause, n_pcause;
        logic        e_ld, e_fl, chk_np, redir;
        logic        n_exl, n_pend, n_fs, n_st;
        e_np = 0; e_ld = 1; e_fl = 0; chk_np = 1; redir = 0;
        n_epc = m_epc; n_cause = m_cause; n_exl = m_exl;
        n_pend = m_pend; n_pcause = m_pcause; n_fs = 0; n_st = m_stalled;
        n_sc = m_sc; n_rc = m_rc;
        if (rst) begin
            e_np = RESET_PC; e_fl = 1;
            n_epc = 0; n_cause = 0; n_exl = 0; n_pend = 0; n_pcause = 0;
            n_st = 0; n_sc = 0; n_rc = 0;
        end else if (m_in_flush_slot) begin
            e_ld = 0; e_fl = 1; chk_np = 0;
        end else if (m_stalled && bus.busy) begin
            e_ld = 0; chk_np = 0;
            if (bus.exc_req && !m_pend) begin
                n_pend = 1; n_pcause = bus.exc_cause;
            end
        end else begin
            n_st = 0;
            if (bus.exc_req || m_pend) begin
                e_np = EXC_BASE; e_fl = 1; redir = 1; n_fs = 1;
                if (!m_exl) n_epc = bus.pc;
                n_cause = m_pend ? m_pcause : bus.exc_cause;
                n_exl = 1; n_pend = 0;
            end else if (bus.eret && m_exl) begin
                e_np = m_epc; e_fl = 1; redir = 1; n_exl = 0;
            end else if (bus.busy) begin
                e_ld = 0; chk_np = 0; n_st = 1;
            end else if (bus.jr) begin
                e_np = bus.jr_target; e_fl = 1; redir = 1;
            end else if (bus.jmp) begin
                e_np = bus.jmp_target; e_fl = 1; redir = 1;
            end else if (bus.br_taken) begin
                e_np = bus.br_target; e_fl = 1; redir = 1;
            end else begin
                e_np = 32'(64'(bus.pc) + 64'd4);
            end
        end
        if (!rst) begin
            if (!e_ld && m_sc != 32'hFFFF_FFFF) n_sc = m_sc + 1;
            if (redir && m_rc != 32'hFFFF_FFFF) n_rc = m_rc + 1;
        end
        #2;
        if (chk_np) check("next_pc", bus.next_pc, e_np);
        check("pc_load", 32'(bus.pc_load), 32'(e_ld));
        check("flush", 32'(bus.flush), 32'(e_fl));
        last_np = e_np;
        @(posedge clk);
        m_epc = n_epc; m_cause = n_cause; m_exl = n_exl; m_pend = n_pend;
        m_pcause = n_pcause; m_in_flush_slot = n_fs; m_stalled = n_st;
        m_sc = n_sc; m_rc = n_rc;
        #1;
        check("epc", epc, m_epc);
        check("cause", 32'(cause), 32'(m_cause));
        check("exl", 32'(exl), 32'(m_exl));
`ifdef PC_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, m_sc);
        check("redir_cnt", redir_cnt, m_rc);
`else
        check("stall_cnt", stall_cnt, 32'd0);
        check("redir_cnt", redir_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset();
        idle(); rst = 1; bus.pc = 32'h0;
        step(); step();
        rst = 0;
    endtask

    initial begin
        m_epc = 0; m_cause = 0; m_exl = 0; m_pend = 0; m_pcause = 0;
        m_in_flush_slot = 0; m_stalled = 0; m_sc = 0; m_rc = 0; last_np = 0;
        rst = 1; idle(); bus.pc = 0;
        @(posedge clk); #1;
        do_reset();
        check("rst_epc", epc, 32'h0);
        check("rst_exl", 32'(exl), 32'h0);

        // sequential from 0
        bus.pc = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_np", last_np, 32'(4 * (i + 1)));
            bus.pc = last_np;
        end

        // exception, flush slot, ERET
        bus.pc = 32'h100; bus.exc_req = 1; bus.exc_cause = 4'b1000;
        step(); idle(); bus.pc = EXC_BASE; step();
        check("exc_epc", epc, 32'h100);
        check("exc_cause", 32'(cause), 32'd8);
        check("exc_exl", 32'(exl), 32'd1);
        bus.eret = 1; step(); idle();
        check("eret_np", last_np, 32'h100);
        check("eret_exl", 32'(exl), 32'd0);

        // nested exception keeps epc
        bus.pc = 32'h100; bus.exc_req = 1; bus.exc_cause = 4'd2; step();
        idle(); step();
        bus.pc = 32'h20; bus.exc_req = 1; bus.exc_cause = 4'd3; step();
        idle(); step();
        check("nest_epc", epc, 32'h100);
        check("nest_cause", 32'(cause), 32'd3);
        bus.eret = 1; step(); idle();
        bus.pc = 32'h40; bus.eret = 1; step(); idle();
        check("eret_nop", last_np, 32'h44);

        // 5-cycle stall with parked trap, then a jump
        do_reset();
        bus.pc = 32'h80; bus.busy = 1;
        for (int i = 0; i < 5; i++) begin
            bus.exc_req = (i == 1); bus.exc_cause = 4'b1101;
            step();
        end
        idle(); step();
        check("stall_exc_np", last_np, EXC_BASE);
        check("stall_exc_cause", 32'(cause), 32'd13);
        step();
        bus.jmp = 1; bus.jmp_target = 32'h200; step(); idle();
`ifdef PC_CTRL_PERF_EN
        check("perf_stall", stall_cnt, 32'd6);
        check("perf_redir", redir_cnt, 32'd2);
`else
        check("perf_stall", stall_cnt, 32'd0);
        check("perf_redir", redir_cnt, 32'd0);
`endif

        // priority and wrap
        bus.jr = 1; bus.jmp = 1; bus.br_taken = 1; bus.pc = 32'h300;
        bus.jr_target = 32'hABC0; step(); idle();
        check("prio_jr", last_np, 32'hABC0);
        bus.pc = 32'hFFFF_FFFC; step();
        check("wrap", last_np, 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom % 150) == 0;
            bus.busy       = ($urandom % 4) == 0;
            bus.exc_req    = ($urandom % 10) == 0;
            bus.exc_cause  = 4'($urandom);
            bus.eret       = ($urandom % 6) == 0;
            bus.jr         = ($urandom % 8) == 0;
            bus.jmp        = ($urandom % 6) == 0;
            bus.br_taken   = ($urandom % 4) == 0;
            bus.jr_target  = $urandom & 32'hFFFF_FFFC;
            bus.jmp_target = $urandom & 32'hFFFF_FFFC;
            bus.br_target  = $urandom & 32'hFFFF_FFFC;
            bus.pc = (($urandom % 20) == 0) ? 32'hFFFF_FFFC
                                            : ($urandom & 32'hFFFF_FFFC);
            step();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
